cordic_sched: RTL and testbench

// - Sequences one cordic_data datapath and shares it between two requesters (0, 1).
// - Round-robin arbitration; valid/ready on both the request and result sides.
// - Sits between client logic and cordic_data. Drives load_regs/add/sub/iter.

---
 rtl/cordic_pkg.sv | 10 +
 rtl/cordic_rr_arb.sv | 16 +
 rtl/cordic_sched.sv | 91 +++++++++
 tb/tb_cordic_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC scheduler: FSM state encoding and requester count.
package cordic_pkg;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } cordic_sched_state_t;
endpackage

// File: rtl/cordic_rr_arb.sv
// Two-way round-robin arbiter; grant_id is always valid, grant is gated by en.
module cordic_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_id
);
  always_comb begin
    grant_id = 1'b0;
    if (req == 2'b11) grant_id = ~last;
    else if (req[1])  grant_id = 1'b1;
    grant = 2'b00;
    if (en && req[grant_id]) grant[grant_id] = 1'b1;
  end
endmodule

// File: rtl/cordic_sched.sv
// Shares one cordic_data datapath between two requesters: arbitration, operand
// mux, step sequencing from the datapath's own step index, and result handshake.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH       = 16,
  parameter int LOG_2_BIT_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_target,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_x,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_y,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              res_id,
  output logic [BIT_WIDTH-1:0]              res_x,
  output logic [BIT_WIDTH-1:0]              res_y,
  output logic                              busy,
  output logic                              dp_load_regs,
  output logic                              dp_add,
  output logic                              dp_sub,
  output logic                              dp_iter,
  output logic [BIT_WIDTH-1:0]              dp_target,
  output logic [BIT_WIDTH-1:0]              dp_in_x,
  output logic [BIT_WIDTH-1:0]              dp_in_y,
  input  logic                              dp_reached_target,
  input  logic                              dp_dir,
  input  logic [BIT_WIDTH-1:0]              dp_x,
  input  logic [BIT_WIDTH-1:0]              dp_y
);
  // The datapath step index must be able to count up to BIT_WIDTH-1.
  if (BIT_WIDTH > (1 << LOG_2_BIT_WIDTH)) begin : g_bad_width
    $error("LOG_2_BIT_WIDTH too small for BIT_WIDTH");
  end

  cordic_sched_state_t state;
  logic                rr_last;
  logic [1:0]          grant;
  logic                grant_id;
  logic                accept;
  logic                rotating;

  // Gating with reset keeps req_ready/load low while reset is held.
  cordic_rr_arb u_arb (
    .req      (req_valid),
    .last     (rr_last),
    .en       ((state == IDLE) && !reset),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign accept    = |grant;
  assign req_ready = grant;
  assign rotating  = (state == ROTATE);

  assign dp_load_regs = accept;
  assign dp_target    = accept ? req_target[grant_id] : '0;
  assign dp_in_x      = accept ? req_x[grant_id]      : '0;
  assign dp_in_y      = accept ? req_y[grant_id]      : '0;
  assign dp_iter      = rotating;
  assign dp_add       = rotating &  dp_dir;
  assign dp_sub       = rotating & ~dp_dir;

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_x     = dp_x;
  assign res_y     = dp_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      res_id  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          res_id  <= grant_id;
          rr_last <= grant_id;
          state   <= ROTATE;
        end
        // The step that sees reached_target is the final one.
        ROTATE: if (dp_reached_target) state <= DONE;
        DONE:   if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched with a behavioural CORDIC datapath and a reference model.
module tb_cordic_sched;
  localparam int BW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][BW-1:0]   req_target, req_x, req_y;
  logic                 res_valid, res_ready, res_id;
  logic [BW-1:0]        res_x, res_y;
  logic                 busy, dp_load_regs, dp_add, dp_sub, dp_iter;
  logic [BW-1:0]        dp_target, dp_in_x, dp_in_y;
  logic                 dp_reached_target, dp_dir;
  logic [BW-1:0]        dp_x, dp_y;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_sched #(.BIT_WIDTH(BW), .LOG_2_BIT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_x(req_x), .req_y(req_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_x(res_x), .res_y(res_y), .busy(busy),
    .dp_load_regs(dp_load_regs), .dp_add(dp_add), .dp_sub(dp_sub), .dp_iter(dp_iter),
    .dp_target(dp_target), .dp_in_x(dp_in_x), .dp_in_y(dp_in_y),
    .dp_reached_target(dp_reached_target), .dp_dir(dp_dir), .dp_x(dp_x), .dp_y(dp_y)
  );

  function automatic logic signed [BW-1:0] atan_lut(input int i);
    case (i)
      0: return 16'sd8192;  1: return 16'sd4836;  2: return 16'sd2555;  3: return 16'sd1297;
      4: return 16'sd651;   5: return 16'sd326;   6: return 16'sd163;   7: return 16'sd81;
      8: return 16'sd41;    9: return 16'sd20;   10: return 16'sd10;   11: return 16'sd5;
      12: return 16'sd3;   13: return 16'sd1;    14: return 16'sd1;    default: return 16'sd0;
    endcase
  endfunction

  // Behavioural cordic_data: z>=0 rotates positive, reached_target at step 15.
  logic signed [BW-1:0] dx, dy, dz;
  logic [3:0]           didx;
  always_ff @(posedge clk) begin
    if (dp_load_regs) begin
      dx <= dp_in_x; dy <= dp_in_y; dz <= dp_target; didx <= 4'd0;
    end else if (dp_iter) begin
      if (dp_add) begin
        dx <= dx - (dy >>> didx); dy <= dy + (dx >>> didx); dz <= dz - atan_lut(int'(didx));
      end else if (dp_sub) begin
        dx <= dx + (dy >>> didx); dy <= dy - (dx >>> didx); dz <= dz + atan_lut(int'(didx));
      end
      didx <= didx + 4'd1;
    end
  end
  assign dp_dir            = ~dz[BW-1];
  assign dp_reached_target = (didx == 4'd15);
  assign dp_x              = dx;
  assign dp_y              = dy;

  function automatic void cordic_ref(input logic [BW-1:0] x0, y0, t0,
                                     output logic [BW-1:0] xo, yo);
    logic signed [BW-1:0] x, y, z, xn, yn;
    x = x0; y = y0; z = t0;
    for (int i = 0; i < BW; i++) begin
      if (!z[BW-1]) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_lut(i);
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_lut(i);
      end
      x = xn; y = yn;
    end
    xo = x; yo = y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          id;
    logic [BW-1:0] x, y;
  } exp_t;
  exp_t sb[$];
  int   grant_q[$];
  int   iter_cnt = 0;
  logic res_valid_d = 1'b0;

  // Scoreboard and per-cycle legality monitor.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      iter_cnt    = 0;
      res_valid_d = 1'b0;
    end else begin
      exp_t e;
      logic g;
      if (|(req_ready & req_valid)) begin
        g = req_ready[1];
        e.id = g;
        cordic_ref(req_x[g], req_y[g], req_target[g], e.x, e.y);
        sb.push_back(e);
        grant_q.push_back(int'(g));
      end
      chk("ready_onehot", {31'd0, req_ready == 2'b11}, 32'd0);
      chk("add_sub_excl", {31'd0, dp_add & dp_sub}, 32'd0);
      chk("load_on_accept", {31'd0, dp_load_regs & ~|(req_ready & req_valid)}, 32'd0);
      if (dp_load_regs) iter_cnt = 0;
      if (dp_iter) iter_cnt++;
      if (res_valid && !res_valid_d) chk("iter_per_op", iter_cnt, 32'd16);
      res_valid_d = res_valid;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_result", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("sb_res_id", {31'd0, res_id}, {31'd0, e.id});
          chk("sb_res_x", {16'd0, res_x}, {16'd0, e.x});
          chk("sb_res_y", {16'd0, res_y}, {16'd0, e.y});
        end
      end
    end
  end

  task automatic do_op(input int id, input logic [BW-1:0] x, y, t, input int hold,
                       output logic [BW-1:0] rx, ry, output logic rid);
    int  cyc;
    bit  ok;
    logic [BW-1:0] hx, hy;
    @(posedge clk); #1;
    req_x[id] = x; req_y[id] = y; req_target[id] = t;
    req_valid[id] = 1'b1; res_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1;
    end
    chk("accept_seen", {31'd0, ok}, 32'd1);
    chk("load_strobe", {31'd0, dp_load_regs}, 32'd1);
    chk("dp_target_mux", {16'd0, dp_target}, {16'd0, t});
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    cyc = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("first_step_add", {31'd0, dp_add}, {31'd0, ~t[BW-1]});
      if (res_valid) ok = 1;
    end
    chk("res_latency", cyc, BW + 1);
    hx = res_x; hy = res_y; rid = res_id;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_stable", {31'd0, res_valid && res_x == hx && res_y == hy && req_ready == 2'b00 &&
          !dp_load_regs && !dp_iter && !dp_add && !dp_sub}, 32'd1);
    end
    rx = res_x; ry = res_y;
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_take", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    int            id;
    logic [BW-1:0] x, y, t;
    int            hold;
    logic [BW-1:0] ex, ey;
  } vec_t;
  vec_t vecs[6];

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] rx, ry, ex, ey;
    logic          rid;
    bit            ok;

    vecs[0] = '{0, 16'h4000, 16'h0000, 16'h1000, 0,  16'h0, 16'h0};
    vecs[1] = '{0, 16'h4000, 16'h0000, 16'hF000, 0,  16'h0, 16'h0};
    vecs[2] = '{1, 16'h2000, 16'h1000, 16'h0800, 10, 16'h0, 16'h0};
    vecs[3] = '{1, 16'hE000, 16'h3000, 16'hC000, 0,  16'h0, 16'h0};
    vecs[4] = '{0, 16'h0000, 16'h0000, 16'h7FFF, 0,  16'h0, 16'h0};
    vecs[5] = '{1, 16'h7FFF, 16'h8001, 16'h2000, 3,  16'h0, 16'h0};
    foreach (vecs[i]) cordic_ref(vecs[i].x, vecs[i].y, vecs[i].t, vecs[i].ex, vecs[i].ey);

    req_valid = 2'b11; req_x = '0; req_y = '0; req_target = '0; res_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_load", {31'd0, dp_load_regs}, 32'd0);
    req_valid = 2'b00;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_res_id", {31'd0, res_id}, 32'd0);
    chk("reset_strobes", {28'd0, dp_load_regs, dp_iter, dp_add, dp_sub}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].t, vecs[i].hold, rx, ry, rid);
      chk($sformatf("vec%0d_id", i), {31'd0, rid}, vecs[i].id);
      chk($sformatf("vec%0d_x", i), {16'd0, rx}, {16'd0, vecs[i].ex});
      chk($sformatf("vec%0d_y", i), {16'd0, ry}, {16'd0, vecs[i].ey});
    end

    // Reset while the datapath is at step 7.
    @(posedge clk); #1;
    req_x[0] = 16'h3000; req_y[0] = 16'h0400; req_target[0] = 16'h0C00; req_valid[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[0]) ok = 1;
    end
    chk("mid_accept_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_strobes", {28'd0, dp_load_regs, dp_iter, dp_add, dp_sub}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    cordic_ref(16'h1234, 16'hF000, 16'hE800, ex, ey);
    do_op(1, 16'h1234, 16'hF000, 16'hE800, 0, rx, ry, rid);
    chk("post_reset_x", {16'd0, rx}, {16'd0, ex});
    chk("post_reset_y", {16'd0, ry}, {16'd0, ey});
    chk("post_reset_id", {31'd0, rid}, 32'd1);

    // Contention from reset: grants must alternate starting with requester 0.
    reset = 1'b1;
    req_x[0] = 16'h4000; req_y[0] = 16'h0000; req_target[0] = 16'h1000;
    req_x[1] = 16'h0000; req_y[1] = 16'h4000; req_target[1] = 16'hF800;
    req_valid = 2'b11; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    grant_q.delete();
    #1 reset = 1'b0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (grant_q.size() >= 4) ok = 1;
    end
    chk("contention_done", {31'd0, ok}, 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant_order%0d", i), (grant_q.size() > i) ? grant_q[i] : 32'hFF, i % 2);
    repeat (40) @(posedge clk);

    // Random traffic; legality and results checked by the monitor.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        req_x[r] = 16'($urandom); req_y[r] = 16'($urandom); req_target[r] = 16'($urandom);
      end
      res_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 req_valid = 2'b00; res_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1;
    end
    chk("random_drain", {31'd0, ok}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
